// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - default geometry constants and control FSM state type for banked_memory
package mem_pkg;

  localparam int N_BANKS_DEF = 257;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - one single-port synchronous RAM bank; BANKED_MEMORY_BYPASS_EN selects write-first forwarding
module memory_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage array: written on we, never reset so contents survive rst
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Registered read port; only loads on a read so the last word is held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (re) begin
`ifdef BANKED_MEMORY_BYPASS_EN
      dout <= we ? din : mem[addr];
`else
      dout <= mem[addr];
`endif
    end
  end

endmodule

// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - N_BANKS independent RAM banks with shared read strobe, 1/2-cycle read latency and clear sweep (BANKED_MEMORY_BYPASS_EN in memory_bank)
module banked_memory
  import mem_pkg::*;
#(
  parameter int N_BANKS = N_BANKS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_BANKS-1:0]          we,
  input  logic [N_BANKS*ADDR_W-1:0]   addr,
  input  logic [N_BANKS*DATA_W-1:0]   din,
  input  logic                        rd_en,
  output logic [N_BANKS*DATA_W-1:0]   dout,
  output logic                        dout_valid,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        clr_done
);

  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                done_nxt;
  logic                rd_fire;
  logic                rd_v1;
  logic [N_BANKS*DATA_W-1:0] ram_dout;

  // Control state, sweep counter and the done pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  // Next-state: start a sweep from IDLE, step the address in CLEAR, leave after the last word
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);

  // A read only counts if we stay in IDLE, so no valid ever surfaces during a sweep
  assign rd_fire = rd_en && (state == IDLE) && (state_nxt == IDLE);

  // First valid stage tracks the RAM output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1 <= 1'b0;
    end else begin
      rd_v1 <= rd_fire;
    end
  end

  for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_din;

    assign b_we   = clr_busy | we[i];
    assign b_addr = clr_busy ? cnt[ADDR_W-1:0] : addr[i*ADDR_W +: ADDR_W];
    assign b_din  = clr_busy ? '0 : din[i*DATA_W +: DATA_W];

    memory_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (b_we),
      .re   (rd_fire),
      .addr (b_addr),
      .din  (b_din),
      .dout (ram_dout[i*DATA_W +: DATA_W])
    );
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                      rd_v2;
    logic [N_BANKS*DATA_W-1:0] dout_q;
    logic                      load;

    assign load = rd_v1 && (state_nxt == IDLE);

    // Extra output stage; holds its word unless a surviving read moves through
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_v2  <= 1'b0;
        dout_q <= '0;
      end else begin
        rd_v2 <= load;
        if (load) begin
          dout_q <= ram_dout;
        end
      end
    end

    assign dout       = dout_q;
    assign dout_valid = rd_v2;
  end else begin : g_lat1
    assign dout       = ram_dout;
    assign dout_valid = rd_v1;
  end

endmodule

// File: tb/tb_banked_memory.sv
// tb/tb_banked_memory.sv - scoreboard bench for banked_memory at RD_LAT=1 (257 banks) and RD_LAT=2 (4 banks)
module tb_banked_memory;

  localparam int NA = 257;
  localparam int NB = 4;
  localparam int WA = NA * 32;
  localparam int WB = NB * 32;

  typedef struct {
    logic [WA-1:0] data;
    int            due;
    string         name;
  } exp_a_t;

  typedef struct {
    logic [WB-1:0] data;
    int            due;
    string         name;
  } exp_b_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;

  logic [NA-1:0]   we_a = '0;
  logic [NA*8-1:0] addr_a = '0;
  logic [WA-1:0]   din_a = '0;
  logic            rd_en_a = 1'b0;
  logic            clr_start_a = 1'b0;
  logic [WA-1:0]   dout_a;
  logic            dout_valid_a, clr_busy_a, clr_done_a;

  logic [NB-1:0]   we_b = '0;
  logic [NB*8-1:0] addr_b = '0;
  logic [WB-1:0]   din_b = '0;
  logic            rd_en_b = 1'b0;
  logic            clr_start_b = 1'b0;
  logic [WB-1:0]   dout_b;
  logic            dout_valid_b, clr_busy_b, clr_done_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int b_beats = 0;

  exp_a_t qa[$];
  exp_b_t qb[$];

  logic [WA-1:0] v034, vzero, v037_init, v037_exp, v037_after, v_fill7, p150, p50;
  logic [WB-1:0] vb;

  banked_memory #(.N_BANKS(NA), .ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .we(we_a), .addr(addr_a), .din(din_a), .rd_en(rd_en_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .clr_start(clr_start_a),
    .clr_busy(clr_busy_a), .clr_done(clr_done_a)
  );

  banked_memory #(.N_BANKS(NB), .ADDR_W(8), .DATA_W(32), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .we(we_b), .addr(addr_b), .din(din_b), .rd_en(rd_en_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .clr_start(clr_start_b),
    .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int first_diff_a(input logic [WA-1:0] x, input logic [WA-1:0] y);
    for (int i = 0; i < NA; i++) begin
      if (x[i*32 +: 32] !== y[i*32 +: 32]) return i;
    end
    return 0;
  endfunction

  function automatic int first_diff_b(input logic [WB-1:0] x, input logic [WB-1:0] y);
    for (int i = 0; i < NB; i++) begin
      if (x[i*32 +: 32] !== y[i*32 +: 32]) return i;
    end
    return 0;
  endfunction

  // Monitor for the RD_LAT=1 instance
  always @(negedge clk) begin
    exp_a_t e;
    int bk;
    if (!rst && dout_valid_a) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_valid: dout_valid got 1 want 0 at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        if (dout_a !== e.data || cyc != e.due) begin
          fails++;
          bk = first_diff_a(dout_a, e.data);
          $display("FAIL %s: bank %0d got %h want %h, cycle %0d want %0d",
                   e.name, bk, dout_a[bk*32 +: 32], e.data[bk*32 +: 32], cyc, e.due);
        end
      end
    end
  end

  // Monitor for the RD_LAT=2 instance
  always @(negedge clk) begin
    exp_b_t e;
    int bk;
    if (!rst && dout_valid_b) begin
      tests++;
      b_beats++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_valid: dout_valid got 1 want 0 at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        if (dout_b !== e.data || cyc != e.due) begin
          fails++;
          bk = first_diff_b(dout_b, e.data);
          $display("FAIL %s: bank %0d got %h want %h, cycle %0d want %0d",
                   e.name, bk, dout_b[bk*32 +: 32], e.data[bk*32 +: 32], cyc, e.due);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic a_write(input int a, input logic [WA-1:0] data);
    @(posedge clk); #1;
    we_a   = '1;
    addr_a = {NA{8'(a)}};
    din_a  = data;
    @(posedge clk); #1;
    we_a   = '0;
  endtask

  task automatic a_read(input int a, input logic [WA-1:0] exp, input string name);
    @(posedge clk); #1;
    addr_a  = {NA{8'(a)}};
    rd_en_a = 1'b1;
    qa.push_back('{data: exp, due: cyc + 1, name: name});
    @(posedge clk); #1;
    rd_en_a = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clr_start_a = 1'b1;
    @(posedge clk); #1;
    clr_start_a = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, bad_done;
    logic prev_busy;

    vzero = '0;
    v034 = '0;
    v034[0*32 +: 32]   = 32'h00ABCDEF;
    v034[255*32 +: 32] = 32'h0000DEAF;
    v034[256*32 +: 32] = 32'h12345678;
    v_fill7 = '0;
    v_fill7[5*32 +: 32] = 32'hFFFFFFFF;
    v037_init = '0;
    v037_init[3*32 +: 32] = 32'h000000AA;
    v037_after = '0;
    v037_after[3*32 +: 32] = 32'h00000055;
`ifdef BANKED_MEMORY_BYPASS_EN
    v037_exp = v037_after;
`else
    v037_exp = v037_init;
`endif
    for (int i = 0; i < NA; i++) begin
      p150[i*32 +: 32] = 32'h15000000 + i;
      p50[i*32 +: 32]  = 32'h05000000 + i;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset_ctrl", {29'd0, clr_busy_a, clr_done_a, dout_valid_a}, 32'd0);
    check("a_reset_dout_zero", {31'd0, dout_a === '0}, 32'd1);
    check("b_reset_ctrl", {29'd0, clr_busy_b, clr_done_b, dout_valid_b}, 32'd0);
    check("b_reset_dout_zero", {31'd0, dout_b === '0}, 32'd1);
    rst = 1'b0;

    // Three-bank pattern at address 0, then hold while idle
    a_write(0, v034);
    a_read(0, v034, "a_read_addr0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_hold_valid_low", {31'd0, dout_valid_a}, 32'd0);
    check("a_hold_dout", {31'd0, dout_a === v034}, 32'd1);

    // Same-cycle read/write collision on bank 3 address 9
    a_write(9, v037_init);
    @(posedge clk); #1;
    we_a = '0;
    we_a[3] = 1'b1;
    addr_a = {NA{8'd9}};
    din_a = v037_after;
    rd_en_a = 1'b1;
    qa.push_back('{data: v037_exp, due: cyc + 1, name: "a_collision"});
    @(posedge clk); #1;
    we_a = '0;
    rd_en_a = 1'b0;
    a_read(9, v037_after, "a_after_collision");

    // Full clear sweep with ignored writes, reads and a restart mid-sweep
    a_write(7, v_fill7);
    pulse_clear();
    busy_cnt = 0; done_cnt = 0; bad_done = 0; prev_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (clr_busy_a) busy_cnt++;
      if (clr_done_a) begin
        done_cnt++;
        if (clr_busy_a || !prev_busy) bad_done++;
      end
      prev_busy = clr_busy_a;
      if (i == 50) begin
        we_a = '1; addr_a = {NA{8'd7}}; din_a = '1; rd_en_a = 1'b1; clr_start_a = 1'b1;
      end else if (i == 51) begin
        we_a = '0; rd_en_a = 1'b0; clr_start_a = 1'b0;
      end
    end
    check("sweep_busy_cycles", busy_cnt, 32'd256);
    check("sweep_done_pulses", done_cnt, 32'd1);
    check("sweep_done_after_busy", bad_done, 32'd0);
    a_read(7, vzero, "a_post_clear_addr7");

    // Reset in the middle of a sweep
    a_write(150, p150);
    a_write(50, p50);
    pulse_clear();
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clr_done_a) done_cnt++;
    end
    rst = 1'b1;
    #1;
    check("abort_busy_in_reset", {31'd0, clr_busy_a}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (clr_done_a) done_cnt++;
      if (clr_busy_a) busy_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_stays_idle", busy_cnt, 32'd0);
    a_read(150, p150, "a_abort_addr150_kept");
    a_read(50, vzero, "a_abort_addr50_cleared");

    // RD_LAT=2: back-to-back reads at addresses 1, 2, 3
    for (int a = 1; a <= 3; a++) begin
      @(posedge clk); #1;
      we_b = '1;
      addr_b = {NB{8'(a)}};
      for (int i = 0; i < NB; i++) din_b[i*32 +: 32] = 32'hB0000000 + a * 256 + i;
    end
    @(posedge clk); #1;
    we_b = '0;
    for (int a = 1; a <= 3; a++) begin
      @(posedge clk); #1;
      addr_b = {NB{8'(a)}};
      rd_en_b = 1'b1;
      for (int i = 0; i < NB; i++) vb[i*32 +: 32] = 32'hB0000000 + a * 256 + i;
      qb.push_back('{data: vb, due: cyc + 2, name: $sformatf("b_read_addr%0d", a)});
    end
    @(posedge clk); #1;
    rd_en_b = 1'b0;

    // Drain both scoreboards with a bounded wait
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);
    check("b_valid_beats", b_beats, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
